alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
// - Shares the single combinational ALU between two requesters: req0 (pipeline EX) and req1 (secondary/debug issue).
// - Round-robin grant, valid/ready handshake on each request and on the response.
// - Sequences multi-cycle MUL: the ALU inputs are held stable for MUL_LAT cycles before the result is sampled.
// - Sits between the issuing units and the ALU; drives the ALU a/b/func and samples its result.
// PARAMETERS
// - WIDTH    32  operand/result width
// - FUNC_W   6   ALU function code width
// - MUL_LAT  3   EXEC cycles for MUL (func 6'b000010); legal range >=1
// PORTS
// - clk          in   1       clock; all state changes on the rising edge
// - rst_n        in   1       asynchronous, active-low reset
// - req0_valid   in   1       requester 0 has an operation
// - req0_ready   out  1       requester 0 accepted this cycle
// - req0_a/_b    in   WIDTH   requester 0 operands
// - req0_func    in   FUNC_W  requester 0 function code
// - req1_*       -    -       same set for requester 1
// - alu_a/_b     out  WIDTH   to ALU operands
// - alu_func     out  FUNC_W  to ALU function code
// - alu_result   in   WIDTH   from ALU, combinational
// - rsp_valid    out  1       response available
// - rsp_ready    in   1       consumer takes the response
// - rsp_id       out  1       requester that owns the response
// - rsp_result   out  WIDTH   registered ALU result
// - rsp_err      out  1       unsupported function code (see CONFIGURATION)
// - busy         out  1       state != IDLE
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, rr_last=1 (so req0 wins first); rsp_valid/rsp_id/rsp_err=0; rsp_result=0.
//   Operand regs, func reg and cnt=0; alu_a/alu_b/alu_func=0.
// - Reset mid-operation drops the in-flight op silently. No response is produced for it.
// - FSM state IDLE:
//   - grant = the sole valid requester; if both are valid, grant != rr_last.
//   - reqN_ready = (state==IDLE) & grant==N. It is combinational from valid. The other ready is 0.
//   - On accept: capture a/b/func/id, set rr_last=id, load cnt; go to EXEC.
//   - cnt loads MUL_LAT-1 when func==MUL, otherwise 0.
// - FSM state EXEC:
//   - alu_a/alu_b/alu_func are driven from the captured regs and stay stable for the whole state.
//   - If cnt!=0: cnt decrements.
//   - If cnt==0: rsp_result<=alu_result, rsp_id<=id, rsp_valid<=1; go to RESP.
// - FSM state RESP:
//   - rsp_valid=1; rsp_result/rsp_id/rsp_err are held stable until rsp_ready.
//   - On rsp_ready: rsp_valid<=0; go to IDLE.
//   - No grant is made in the handshake cycle.
// - ALU input drive: alu_a/alu_b/alu_func = 0 in IDLE and RESP. func 0 makes the ALU output 0, so the ALU stays quiet.
// - Latency: accept at cycle T gives rsp_valid at T+2 (non-MUL) or T+1+MUL_LAT (MUL).
// - Minimum issue interval: 3 cycles (non-MUL) with rsp_ready held high.
// - A requester dropping valid before ready is legal; nothing is captured.
// - Operands are captured only on accept. Later changes on the reqN_a/b/func inputs have no effect.
// - Width rules: result is WIDTH bits exactly as returned by the ALU. MUL is truncated to the low WIDTH bits. No overflow flag.
// - cnt width is $clog2(MUL_LAT+1).
// CONFIGURATION
// - Macro ALU_FUNC_CHECK_EN.
// - Defined: an accepted func outside {20,22,24,25,2A,02,08,0C,0D}h skips EXEC.
//   - Next cycle: rsp_valid=1, rsp_result=0, rsp_err=1.
//   - alu_* stay 0.
//   - rr_last is updated as normal.
// - Undefined: every func goes through EXEC (1 cycle if not MUL) and rsp_err is tied 0.
// TESTING
// - Single ADD: req0 a=5 b=7 func=20h at T -> rsp_valid at T+2, rsp_result=12, rsp_id=0.
// - Both valid every cycle after reset, rsp_ready=1:
//   - grants alternate 0,1,0,1.
//   - Each response id matches its request.
//   - Never two readys in the same cycle.
// - MUL: req1 a=6 b=7 func=02h, MUL_LAT=3:
//   - alu_func=02h for exactly 3 cycles.
//   - rsp_result=42 at T+4.
//   - req0_ready stays 0 meanwhile.
// - Backpressure: rsp_ready=0 for 5 cycles:
//   - rsp_valid, rsp_result and rsp_id stay stable.
//   - No new ready until 1 cycle after rsp_ready=1.
// - Reset mid-MUL: rst_n low during EXEC:
//   - busy, rsp_valid and alu_* are 0 immediately, without waiting for clk.
//   - After release, req0 wins a simultaneous request.
// - ALU_FUNC_CHECK_EN: func=3Fh -> rsp_err=1, rsp_result=0 at T+1.
//   - Without the macro: rsp_err=0, result 0 at T+2.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters with a
// round-robin grant, holds the ALU inputs for MUL_LAT cycles on MUL, and
// returns the registered result over a valid/ready response port.
// Optional feature: define ALU_FUNC_CHECK_EN to reject unsupported function
// codes with rsp_err=1 and a zero result instead of running them on the ALU.
module alu_share_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FUNC_W  = 6,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [WIDTH-1:0]  alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_err,
  output logic              busy
);

  localparam int unsigned       CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [FUNC_W-1:0] FUNC_MUL = FUNC_W'(6'h02);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_d;
  logic               rr_last;
  logic               id_q;
  logic [CNT_W-1:0]   cnt;
  logic               grant_c;
  logic               accept_c;
  logic               func_ok_c;
  logic [WIDTH-1:0]   sel_a_c;
  logic [WIDTH-1:0]   sel_b_c;
  logic [FUNC_W-1:0]  sel_func_c;

  assign busy = (state != IDLE);

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_c = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_c = ~rr_last;
    end else if (req1_valid) begin
      grant_c = 1'b1;
    end
    sel_a_c    = grant_c ? req1_a    : req0_a;
    sel_b_c    = grant_c ? req1_b    : req0_b;
    sel_func_c = grant_c ? req1_func : req0_func;
  end

`ifdef ALU_FUNC_CHECK_EN
  // Function codes the ALU actually implements.
  always_comb begin
    func_ok_c = 1'b0;
    case (sel_func_c)
      FUNC_W'(6'h20), FUNC_W'(6'h22), FUNC_W'(6'h24),
      FUNC_W'(6'h25), FUNC_W'(6'h2A), FUNC_W'(6'h02),
      FUNC_W'(6'h08), FUNC_W'(6'h0C), FUNC_W'(6'h0D): func_ok_c = 1'b1;
      default:                                         func_ok_c = 1'b0;
    endcase
  end
`else
  // Every function code is sent to the ALU.
  always_comb begin
    func_ok_c = 1'b1;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and the combinational request readys (only offered in IDLE).
  always_comb begin
    state_d    = state;
    accept_c   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        accept_c   = req0_valid | req1_valid;
        req0_ready = accept_c & ~grant_c;
        req1_ready = accept_c & grant_c;
        if (accept_c) begin
          state_d = func_ok_c ? EXEC : RESP;
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture into the ALU drive regs, MUL hold counter and response regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last    <= 1'b1;
      id_q       <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_func   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            rr_last <= grant_c;
            id_q    <= grant_c;
            if (func_ok_c) begin
              alu_a    <= sel_a_c;
              alu_b    <= sel_b_c;
              alu_func <= sel_func_c;
              cnt      <= (sel_func_c == FUNC_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
            end else begin
              // Rejected op: answer next cycle, ALU inputs stay quiet.
              rsp_valid  <= 1'b1;
              rsp_id     <= grant_c;
              rsp_result <= '0;
            end
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rsp_valid  <= 1'b1;
            rsp_id     <= id_q;
            rsp_result <= alu_result;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_func   <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_FUNC_CHECK_EN
  logic err_q;

  // Error flag is decided at accept and held through EXEC/RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept_c) begin
      err_q <= ~func_ok_c;
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule
